// File: rtl/snes_autojoy_pkg.sv
// Shared types and constants for the SNES auto-joypad read engine.
package snes_autojoy_pkg;

  localparam int NUM_BITS = 16;
  localparam int CNT_W    = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    CLK_HI = 3'd2,
    CLK_LO = 3'd3,
    DONE   = 3'd4
  } autojoy_state_t;

endpackage

// File: rtl/snes_autojoy_if.sv
// Port/register-file bus of the auto-joypad engine; the CPU_* manual-access
// signals exist only when SNES_AUTOJOY_MANUAL_EN is defined.
import snes_autojoy_pkg::*;

interface snes_autojoy_if;
  logic                START;
  logic                ENABLE;
  logic [1:0]          PORT_DO;
  logic                PORT_LATCH;
  logic                PORT_CLK;
  logic                BUSY;
  logic [NUM_BITS-1:0] JOY_D0;
  logic [NUM_BITS-1:0] JOY_D1;
  autojoy_state_t      DBG_STATE;
`ifdef SNES_AUTOJOY_MANUAL_EN
  logic                CPU_LATCH;
  logic                CPU_CLK_STB;
  logic [1:0]          CPU_DO;

  modport master (
    input  START, ENABLE, PORT_DO, CPU_LATCH, CPU_CLK_STB,
    output PORT_LATCH, PORT_CLK, BUSY, JOY_D0, JOY_D1, DBG_STATE, CPU_DO
  );
  modport slave (
    output START, ENABLE, PORT_DO, CPU_LATCH, CPU_CLK_STB,
    input  PORT_LATCH, PORT_CLK, BUSY, JOY_D0, JOY_D1, DBG_STATE, CPU_DO
  );
`else
  modport master (
    input  START, ENABLE, PORT_DO,
    output PORT_LATCH, PORT_CLK, BUSY, JOY_D0, JOY_D1, DBG_STATE
  );
  modport slave (
    output START, ENABLE, PORT_DO,
    input  PORT_LATCH, PORT_CLK, BUSY, JOY_D0, JOY_D1, DBG_STATE
  );
`endif
endinterface

// File: rtl/snes_autojoy_phase_timer.sv
// Loadable down-counter timing one phase of HALF_PERIOD (or 2x with dbl_i);
// expire_o pulses on the last cycle of the phase.
module autojoy_phase_timer #(
  parameter int HALF_PERIOD = 96
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dbl_i,
  output logic expire_o
);
  localparam int TW = $clog2(2 * HALF_PERIOD);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  assign expire_o = run_q & (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load_i) begin
      cnt_d = dbl_i ? TW'(2 * HALF_PERIOD - 1) : TW'(HALF_PERIOD - 1);
      run_d = 1'b1;
    end else if (expire_o) begin
      run_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/snes_autojoy.sv
// Auto-joypad read engine: latch + 16 serial clocks per vblank, results held in JOY_D0/JOY_D1.
// Optional CPU manual port access is compiled in with SNES_AUTOJOY_MANUAL_EN.
import snes_autojoy_pkg::*;

module snes_autojoy #(
  parameter int HALF_PERIOD = 96
) (
  input  logic           CLK,
  input  logic           RST,
  snes_autojoy_if.master bus
);
  autojoy_state_t      state_q, state_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [NUM_BITS-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic [NUM_BITS-1:0] joy0_q, joy0_d, joy1_q, joy1_d;
  logic                latch_q, latch_d, pclk_q, pclk_d, busy_q, busy_d;
  logic                fsm_load, fsm_dbl, tmr_load, tmr_expire, go;

`ifdef SNES_AUTOJOY_MANUAL_EN
  logic       man_lo_q, man_lo_d, pend_q, pend_d, man_stb;
  logic [1:0] cpu_do_q, cpu_do_d;

  // A START seen while a manual clock-low window is open waits for PORT_CLK to rise.
  assign go       = (bus.START | pend_q) & bus.ENABLE & ~man_lo_q;
  assign man_stb  = (state_q == IDLE) & bus.CPU_CLK_STB & ~bus.CPU_LATCH & ~man_lo_q & ~go;
  assign pend_d   = (state_q == IDLE) & man_lo_q & (bus.START | pend_q);
  assign man_lo_d = man_stb ? 1'b1 : ((man_lo_q & tmr_expire) ? 1'b0 : man_lo_q);
  assign cpu_do_d = man_stb ? ~bus.PORT_DO : cpu_do_q;
  assign tmr_load = fsm_load | man_stb;
  assign latch_d  = (state_d == LATCH) | ((state_d == IDLE) & bus.CPU_LATCH & ~man_lo_d);
  assign pclk_d   = (state_d != CLK_LO) & ~man_lo_d;
  assign bus.CPU_DO = cpu_do_q;
`else
  assign go       = bus.START & bus.ENABLE;
  assign tmr_load = fsm_load;
  assign latch_d  = (state_d == LATCH);
  assign pclk_d   = (state_d != CLK_LO);
`endif

  assign busy_d = (state_d != IDLE);

  autojoy_phase_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
    .clk_i    (CLK),
    .rst_i    (RST),
    .load_i   (tmr_load),
    .dbl_i    (fsm_dbl),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    sh0_d    = sh0_q;
    sh1_d    = sh1_q;
    joy0_d   = joy0_q;
    joy1_d   = joy1_q;
    fsm_load = 1'b0;
    fsm_dbl  = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d  = LATCH;
          bit_d    = '0;
          fsm_load = 1'b1;
          fsm_dbl  = 1'b1;
        end
      end
      LATCH: begin
        if (tmr_expire) begin
          state_d  = CLK_HI;
          fsm_load = 1'b1;
        end
      end
      CLK_HI: begin
        // Data is taken at the end of the high phase, just before PORT_CLK falls.
        if (tmr_expire) begin
          sh0_d    = {sh0_q[NUM_BITS-2:0], ~bus.PORT_DO[0]};
          sh1_d    = {sh1_q[NUM_BITS-2:0], ~bus.PORT_DO[1]};
          state_d  = CLK_LO;
          fsm_load = 1'b1;
        end
      end
      CLK_LO: begin
        if (tmr_expire) begin
          bit_d    = bit_q + CNT_W'(1);
          state_d  = (bit_d < CNT_W'(NUM_BITS)) ? CLK_HI : DONE;
          fsm_load = 1'b1;
        end
      end
      DONE: begin
        joy0_d  = sh0_q;
        joy1_d  = sh1_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      joy0_q  <= '0;
      joy1_q  <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      joy0_q  <= joy0_d;
      joy1_q  <= joy1_d;
      latch_q <= latch_d;
      pclk_q  <= pclk_d;
      busy_q  <= busy_d;
    end
  end

`ifdef SNES_AUTOJOY_MANUAL_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      man_lo_q <= 1'b0;
      pend_q   <= 1'b0;
      cpu_do_q <= '0;
    end else begin
      man_lo_q <= man_lo_d;
      pend_q   <= pend_d;
      cpu_do_q <= cpu_do_d;
    end
  end
`endif

  assign bus.PORT_LATCH = latch_q;
  assign bus.PORT_CLK   = pclk_q;
  assign bus.BUSY       = busy_q;
  assign bus.JOY_D0     = joy0_q;
  assign bus.JOY_D1     = joy1_q;
  assign bus.DBG_STATE  = state_q;
endmodule
